// File: rtl/cpu_bus_memory.sv
// cpu_bus_memory: synchronous word memory on the CPU bus with a req/ready
// handshake, a configurable wait-state count and out-of-range error reporting.
// Optional access statistics are enabled by defining CPU_BUS_MEMORY_STATS_EN.
module cpu_bus_memory #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] address_bus,
  input  logic [DATA_W-1:0] data_bus_out,
  output logic [DATA_W-1:0] data_bus_in,
  output logic              ready,
  output logic              err,
  output logic              busy
`ifdef CPU_BUS_MEMORY_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);

  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      WAIT_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   dbi_q;
  logic                ready_q;
  logic                err_q;
  logic                busy_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                in_idle;
  logic                acc_we;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_data;
  logic                enter_resp;
  logic                in_range;
  logic [IDX_W-1:0]    mem_idx;
  logic                mem_wr;

  // Operands of the access completing this edge: with zero wait states the
  // access completes on its acceptance edge, so the live bus is used directly.
  always_comb begin
    in_idle    = (state_q == S_IDLE);
    acc_we     = in_idle ? we           : we_q;
    acc_addr   = in_idle ? address_bus  : addr_q;
    acc_data   = in_idle ? data_bus_out : data_q;
    enter_resp = (in_idle && req && (WAIT_STATES == 0)) ||
                 ((state_q == S_WAIT) && (cnt_q == '0));
    in_range   = ({1'b0, acc_addr} < DEPTH_L);
    mem_idx    = acc_addr[IDX_W-1:0];
    mem_wr     = reset && enter_resp && acc_we && in_range;
  end

  // Handshake FSM with registered outputs and read-data capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      dbi_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req) begin
            we_q   <= we;
            addr_q <= address_bus;
            data_q <= data_bus_out;
            busy_q <= 1'b1;
            if (WAIT_STATES == 0) begin
              state_q <= S_RESP;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= WAIT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 4'd1;
          else             state_q <= S_RESP;
        end
        S_RESP: begin
          state_q <= S_IDLE;
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase

      if (enter_resp) begin
        ready_q <= 1'b1;
        err_q   <= !in_range;
        if (!in_range)   dbi_q <= '0;
        else if (!acc_we) dbi_q <= mem[mem_idx];
      end
    end
  end

  // Memory array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_wr) mem[mem_idx] <= acc_data;
  end

`ifdef CPU_BUS_MEMORY_STATS_EN
  logic [15:0] rd_cnt_q;
  logic [15:0] wr_cnt_q;

  // Saturating counters of successful reads and writes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (enter_resp && in_range) begin
      if (acc_we) begin
        if (wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 16'd1;
      end else begin
        if (rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 16'd1;
      end
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

  assign data_bus_in = dbi_q;
  assign ready       = ready_q;
  assign err         = err_q;
  assign busy        = busy_q;

endmodule

// File: doc/cpu_bus_memory.md
Name: cpu_bus_memory

Overview:
- Parametrised synchronous memory model on the CPU's address/data bus, with a req/ready handshake and a configurable wait-state count.
- Successor to the fixed, untimed bus hookup around the CPU: serves CPU instruction/data accesses in simulation and FPGA builds.
- Adds wait-state timing, out-of-range error reporting, and optional access statistics.

Parameters:
- DATA_W, 32, data bus width in bits.
- ADDR_W, 16, word-address width.
- DEPTH, 1024, number of DATA_W words; must satisfy DEPTH <= 2**ADDR_W.
- WAIT_STATES, 2, extra cycles inserted before ready; legal range 0..15.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- req  in  1  CPU access request; sampled only in IDLE.
- we  in  1  1 = write, 0 = read; captured with req.
- address_bus  in  ADDR_W  word address; captured with req.
- data_bus_out  in  DATA_W  CPU write data; captured with req.
- data_bus_in  out  DATA_W  read data returned to the CPU.
- ready  out  1  one-cycle completion strobe.
- err  out  1  out-of-range flag; valid only while ready=1.
- busy  out  1  high from acceptance until the ready cycle, inclusive.

Behaviour:
- Reset (reset=0 at an edge):
  - State goes to IDLE; wait counter = 0.
  - ready=0, err=0, busy=0, data_bus_in=0.
  - Memory array is not cleared.
  - Reset wins over any same-edge event; an in-flight transaction is aborted and a pending write is discarded.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On req=1, capture we, address_bus and data_bus_out; set busy=1.
  - If WAIT_STATES=0, go to RESP; otherwise go to WAIT with counter = WAIT_STATES-1.
  - req=0 keeps the FSM in IDLE.
- WAIT:
  - counter>0: decrement.
  - counter=0: go to RESP.
  - req, we, address and data inputs are ignored.
- Transition into RESP (same edge):
  - In-range write: mem[addr] <= captured data.
  - In-range read: data_bus_in <= mem[addr].
  - Out of range (addr >= DEPTH): no write; data_bus_in <= 0; err <= 1.
- RESP: ready=1 for exactly one cycle, then go to IDLE with ready=0, err=0, busy=0.
- After a write, data_bus_in holds its previous value (it changes only on reads).
- Latency: if req is sampled at edge E, ready is high in the cycle after edge E+WAIT_STATES.
- Back-to-back: a req held high through RESP is accepted at the first IDLE edge. Throughput is one access per WAIT_STATES+2 cycles.
- Read-after-write to the same address returns the newly written data.
- Address arithmetic is unsigned. There is no wrap-around: addresses at or above DEPTH always raise err.

Optional Feature:
- Macro: CPU_BUS_MEMORY_STATS_EN.
- With the macro defined:
  - Adds outputs rd_count (16 bits) and wr_count (16 bits).
  - Each increments in the RESP cycle of an in-range read or write, respectively.
  - Each saturates at 16'hFFFF.
  - Errored accesses are not counted.
  - Both are cleared by reset.
- Without the macro: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- WAIT_STATES=2: write 32'hDEADBEEF to addr 5 (req sampled at edge 0), then read addr 5 -> ready=1 only in the cycle after edge 2 for each access; read returns 32'hDEADBEEF; err=0.
- WAIT_STATES=0, req held high for 3 reads of addrs 0, 1, 2 preloaded with 1, 2, 3 -> ready on alternate cycles; data_bus_in = 1, 2, 3 in turn.
- DEPTH=1024: write then read addr 1024 -> err=1 with ready on both; read data_bus_in=0; mem[0] unchanged.
- Reset asserted low during WAIT of a write of 32'h12345678 to addr 7 -> ready never pulses; a subsequent read of addr 7 returns the old contents; all outputs 0 during reset.
- While in WAIT, change address_bus and data_bus_out -> the captured values are used; changed values are ignored.
- With CPU_BUS_MEMORY_STATS_EN defined: 3 reads, 2 writes, 1 out-of-range read -> rd_count=3, wr_count=2; forcing 70000 reads -> rd_count saturates at 16'hFFFF.
